sram_b_port_arbiter: RTL and testbench

SRAM_B_PORT_ARBITER -- requirements
Module: sram_b_port_arbiter

---
 rtl/sram_b_port_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_b_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_b_port_arbiter.sv
// Arbiter for an SRAM with one write port and one shared read port serving two requesters.
// Define SRAM_B_ARB_FIXED_PRIO_EN to make requester 0 always win contention instead of round-robin.
module sram_b_port_arbiter #(
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          WR_VALID,
    output logic          WR_READY,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [DW-1:0] WR_DATA,
    input  logic [DW-1:0] WR_MASK,
    input  logic          RD0_VALID,
    output logic          RD0_READY,
    input  logic [AW-1:0] RD0_ADDR,
    input  logic          RD1_VALID,
    output logic          RD1_READY,
    input  logic [AW-1:0] RD1_ADDR,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic          RSP_ID,
    output logic [DW-1:0] RSP_DATA,
    output logic          SRAM_CE0,
    output logic          SRAM_WE0,
    output logic [AW-1:0] SRAM_A0,
    output logic [DW-1:0] SRAM_D0,
    output logic [DW-1:0] SRAM_WEM0,
    output logic          SRAM_CE1,
    output logic [AW-1:0] SRAM_A1,
    input  logic [DW-1:0] SRAM_Q1
);

    logic          wr_hs;
    logic          pop;
    logic          credit_ok;
    logic          elig0, elig1;
    logic          gnt0, gnt1, gnt_any;
    logic [1:0]    credit;
    logic          inflight, inflight_id;
    logic [DW-1:0] fifo_data [2];
    logic          fifo_id   [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    count;
`ifndef SRAM_B_ARB_FIXED_PRIO_EN
    logic          last_gnt;
`endif

    assign WR_READY  = ~RST;
    assign wr_hs     = WR_VALID & WR_READY;
    assign SRAM_CE0  = wr_hs;
    assign SRAM_WE0  = wr_hs;
    assign SRAM_A0   = wr_hs ? WR_ADDR : '0;
    assign SRAM_D0   = wr_hs ? WR_DATA : '0;
    assign SRAM_WEM0 = wr_hs ? WR_MASK : '0;

    assign RSP_VALID = (count != 2'd0) & ~RST;
    assign RSP_ID    = RST ? 1'b0 : fifo_id[rd_ptr];
    assign RSP_DATA  = RST ? '0 : fifo_data[rd_ptr];
    assign pop       = RSP_VALID & RSP_READY;

    // A pop in the same cycle frees a slot, which keeps one read per cycle at full throughput.
    assign credit_ok = (credit != 2'd0) | pop;
    assign elig0     = ~RST & RD0_VALID & credit_ok & ~(wr_hs & (WR_ADDR == RD0_ADDR));
    assign elig1     = ~RST & RD1_VALID & credit_ok & ~(wr_hs & (WR_ADDR == RD1_ADDR));

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (elig0 && elig1) begin
`ifdef SRAM_B_ARB_FIXED_PRIO_EN
            gnt0 = 1'b1;
`else
            gnt0 = last_gnt;
            gnt1 = ~last_gnt;
`endif
        end else begin
            gnt0 = elig0;
            gnt1 = elig1;
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign RD0_READY = gnt0;
    assign RD1_READY = gnt1;
    assign SRAM_CE1  = gnt_any;
    assign SRAM_A1   = gnt1 ? RD1_ADDR : (gnt0 ? RD0_ADDR : '0);

    // Credit tracks in-flight plus queued reads, so the 2-entry FIFO cannot overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            credit       <= 2'd2;
            inflight     <= 1'b0;
            inflight_id  <= 1'b0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= 2'd0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_id[0]   <= 1'b0;
            fifo_id[1]   <= 1'b0;
        end else begin
            inflight    <= gnt_any;
            inflight_id <= gnt1;
            if (gnt_any && !pop)
                credit <= credit - 2'd1;
            else if (pop && !gnt_any)
                credit <= credit + 2'd1;
            if (inflight) begin
                fifo_data[wr_ptr] <= SRAM_Q1;
                fifo_id[wr_ptr]   <= inflight_id;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

`ifndef SRAM_B_ARB_FIXED_PRIO_EN
    // Pointer resets to 1 so requester 0 takes the first contention.
    always_ff @(posedge CLK) begin
        if (RST)
            last_gnt <= 1'b1;
        else if (gnt_any)
            last_gnt <= gnt1;
    end
`endif

endmodule

// File: tb/tb_sram_b_port_arbiter.sv
// Directed bench for sram_b_port_arbiter with an SRAM model and an in-order response scoreboard.
// Expectations follow SRAM_B_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_sram_b_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 8;
`ifdef SRAM_B_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          CLK, RST;
    logic          WR_VALID, WR_READY;
    logic [AW-1:0] WR_ADDR;
    logic [DW-1:0] WR_DATA, WR_MASK;
    logic          RD0_VALID, RD0_READY, RD1_VALID, RD1_READY;
    logic [AW-1:0] RD0_ADDR, RD1_ADDR;
    logic          RSP_VALID, RSP_READY, RSP_ID;
    logic [DW-1:0] RSP_DATA;
    logic          SRAM_CE0, SRAM_WE0, SRAM_CE1;
    logic [AW-1:0] SRAM_A0, SRAM_A1;
    logic [DW-1:0] SRAM_D0, SRAM_WEM0, SRAM_Q1;

    sram_b_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA), .WR_MASK(WR_MASK),
        .RD0_VALID(RD0_VALID), .RD0_READY(RD0_READY), .RD0_ADDR(RD0_ADDR),
        .RD1_VALID(RD1_VALID), .RD1_READY(RD1_READY), .RD1_ADDR(RD1_ADDR),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA),
        .SRAM_CE0(SRAM_CE0), .SRAM_WE0(SRAM_WE0), .SRAM_A0(SRAM_A0),
        .SRAM_D0(SRAM_D0), .SRAM_WEM0(SRAM_WEM0),
        .SRAM_CE1(SRAM_CE1), .SRAM_A1(SRAM_A1), .SRAM_Q1(SRAM_Q1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_lat = 1'b0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] def_val(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a;
        return t[7:0] ^ 8'h3C;
    endfunction

    // SRAM model driven only by the DUT's SRAM pins
    logic [DW-1:0] sram [logic [AW-1:0]];
    function automatic logic [DW-1:0] sram_rd(input logic [AW-1:0] a);
        return sram.exists(a) ? sram[a] : def_val(a);
    endfunction
    initial SRAM_Q1 = '0;
    always @(posedge CLK) begin
        if (SRAM_CE1) SRAM_Q1 <= sram_rd(SRAM_A1);
        if (SRAM_CE0 && SRAM_WE0)
            sram[SRAM_A0] = (sram_rd(SRAM_A0) & ~SRAM_WEM0) | (SRAM_D0 & SRAM_WEM0);
    end

    // Shadow memory updated from the writes the bench issues
    logic [DW-1:0] shadow [logic [AW-1:0]];
    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : def_val(a);
    endfunction

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            gcyc;
    } exp_t;
    exp_t sb[$];

    logic          held_v, held_id;
    logic [DW-1:0] held_d;

    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            sb.delete();
            held_v = 1'b0;
        end else begin
            chk("ready_onehot", {31'd0, RD0_READY & RD1_READY}, 32'd0);
            if (held_v && RSP_VALID) begin
                chk("rsp_data_stable", RSP_DATA, held_d);
                chk("rsp_id_stable", RSP_ID, held_id);
            end
            held_v  = RSP_VALID && !RSP_READY;
            held_d  = RSP_DATA;
            held_id = RSP_ID;
            if (RSP_VALID && RSP_READY) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL rsp_unexpected: observed id %0d data %0h expected no response", RSP_ID, RSP_DATA);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_id", RSP_ID, e.id);
                    chk("rsp_data", RSP_DATA, e.data);
                    if (chk_lat) chk("rsp_latency", cyc - e.gcyc, 2);
                end
            end
            if (RD0_READY) begin
                chk("rd0_ready_needs_valid", RD0_VALID, 1);
                sb.push_back('{1'b0, shadow_rd(RD0_ADDR), cyc});
            end
            if (RD1_READY) begin
                chk("rd1_ready_needs_valid", RD1_VALID, 1);
                sb.push_back('{1'b1, shadow_rd(RD1_ADDR), cyc});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, WR_READY, 0);
        chk({tag, "_rd0_ready"}, RD0_READY, 0);
        chk({tag, "_rd1_ready"}, RD1_READY, 0);
        chk({tag, "_sram_ce0"}, SRAM_CE0, 0);
        chk({tag, "_sram_we0"}, SRAM_WE0, 0);
        chk({tag, "_sram_a0"}, SRAM_A0, 0);
        chk({tag, "_sram_d0"}, SRAM_D0, 0);
        chk({tag, "_sram_wem0"}, SRAM_WEM0, 0);
        chk({tag, "_sram_ce1"}, SRAM_CE1, 0);
        chk({tag, "_sram_a1"}, SRAM_A1, 0);
        chk({tag, "_rsp_valid"}, RSP_VALID, 0);
        chk({tag, "_rsp_id"}, RSP_ID, 0);
        chk({tag, "_rsp_data"}, RSP_DATA, 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        WR_VALID = 1'b1; WR_ADDR = a; WR_DATA = d; WR_MASK = m;
        shadow[a] = (shadow_rd(a) & ~m) | (d & m);
    endtask

    initial begin
        int exp_g;
        RST = 1'b1; RSP_READY = 1'b0;
        WR_VALID = 1'b1; WR_ADDR = 14'h0055; WR_DATA = 8'hFF; WR_MASK = 8'hFF;
        RD0_VALID = 1'b1; RD0_ADDR = 14'h0010; RD1_VALID = 1'b1; RD1_ADDR = 14'h0020;
        step(); step();
        smp();
        reset_outputs("por");

        // Contention with continuous requests and full-rate drain
        step();
        RST = 1'b0; WR_VALID = 1'b0; RSP_READY = 1'b1; chk_lat = 1'b1;
        for (int i = 0; i < 6; i++) begin
            smp();
            exp_g = FIXED ? 0 : i % 2;
            chk("rr_rd0_ready", RD0_READY, exp_g == 0);
            chk("rr_rd1_ready", RD1_READY, exp_g == 1);
            chk("rr_sram_ce1", SRAM_CE1, 1);
            chk("rr_sram_a1", SRAM_A1, exp_g == 1 ? 14'h0020 : 14'h0010);
            chk("rr_rsp_valid", RSP_VALID, i >= 2);
            if (i >= 2) chk("rr_rsp_id", RSP_ID, FIXED ? 0 : (i - 2) % 2);
            step();
        end
        RD0_VALID = 1'b0; RD1_VALID = 1'b0;
        drain();
        chk_lat = 1'b0;

        // Write then read-back of the same address
        do_write(14'h1234, 8'hA5, 8'hFF);
        smp();
        chk("wr_ready", WR_READY, 1);
        chk("wr_ce0", SRAM_CE0, 1);
        chk("wr_we0", SRAM_WE0, 1);
        chk("wr_a0", SRAM_A0, 14'h1234);
        chk("wr_d0", SRAM_D0, 8'hA5);
        chk("wr_wem0", SRAM_WEM0, 8'hFF);
        step();
        WR_VALID = 1'b0; RD0_VALID = 1'b1; RD0_ADDR = 14'h1234;
        smp();
        chk("rb_rd0_ready", RD0_READY, 1);
        chk("rb_sram_a1", SRAM_A1, 14'h1234);
        chk("idle_ce0", SRAM_CE0, 0);
        chk("idle_a0", SRAM_A0, 0);
        step();
        RD0_VALID = 1'b0;
        smp();
        chk("rb_rsp_not_yet", RSP_VALID, 0);
        step();
        smp();
        chk("rb_rsp_valid", RSP_VALID, 1);
        chk("rb_rsp_data", RSP_DATA, 8'hA5);
        chk("rb_rsp_id", RSP_ID, 0);
        step();

        // Partial-mask write, read by requester 1
        do_write(14'h1234, 8'h5A, 8'h0F);
        step();
        WR_VALID = 1'b0; RD1_VALID = 1'b1; RD1_ADDR = 14'h1234;
        smp();
        chk("mask_rd1_ready", RD1_READY, 1);
        step();
        RD1_VALID = 1'b0;
        step();
        smp();
        chk("mask_rsp_data", RSP_DATA, 8'hAA);
        chk("mask_rsp_id", RSP_ID, 1);
        step();
        drain();

        // Same-address write stalls the read for one cycle
        do_write(14'h0100, 8'h3C, 8'hFF);
        RD1_VALID = 1'b1; RD1_ADDR = 14'h0100;
        smp();
        chk("hz_rd1_ready", RD1_READY, 0);
        chk("hz_sram_ce1", SRAM_CE1, 0);
        chk("hz_sram_a1", SRAM_A1, 0);
        chk("hz_sram_ce0", SRAM_CE0, 1);
        step();
        WR_VALID = 1'b0;
        smp();
        chk("hz_rd1_ready_next", RD1_READY, 1);
        chk("hz_sram_a1_next", SRAM_A1, 14'h0100);
        step();
        RD1_VALID = 1'b0;
        step();
        smp();
        chk("hz_rsp_data", RSP_DATA, 8'h3C);
        chk("hz_rsp_id", RSP_ID, 1);
        step();
        drain();

        // Write to a different address does not block the read
        do_write(14'h0200, 8'h11, 8'hFF);
        RD0_VALID = 1'b1; RD0_ADDR = 14'h0300;
        smp();
        chk("nohz_rd0_ready", RD0_READY, 1);
        step();
        WR_VALID = 1'b0; RD0_VALID = 1'b0;
        drain();

        // Backpressure: credit limits to two outstanding reads
        RSP_READY = 1'b0; RD0_VALID = 1'b1; RD0_ADDR = 14'h0040;
        for (int i = 0; i < 6; i++) begin
            smp();
            chk("bp_rd0_ready", RD0_READY, i < 2);
            step();
        end
        RSP_READY = 1'b1;
        smp();
        chk("bp_resume_rsp_valid", RSP_VALID, 1);
        chk("bp_resume_rd0_ready", RD0_READY, 1);
        step();
        RD0_VALID = 1'b0;
        drain();

        // Reset while a read is in flight
        RD0_VALID = 1'b1; RD0_ADDR = 14'h0010;
        smp();
        chk("rip_grant", RD0_READY, 1);
        step();
        RST = 1'b1; RD1_VALID = 1'b1; WR_VALID = 1'b1; WR_ADDR = 14'h0077;
        smp();
        reset_outputs("rip");
        step();
        RST = 1'b0; RD0_VALID = 1'b0; RD1_VALID = 1'b0; WR_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("rip_no_rsp", RSP_VALID, 0);
            step();
        end
        RSP_READY = 1'b0; RD0_VALID = 1'b1; RD1_VALID = 1'b1;
        smp();
        chk("rip_first_rd0", RD0_READY, 1);
        chk("rip_first_rd1", RD1_READY, 0);
        step();
        smp();
        chk("rip_second_rd0", RD0_READY, FIXED);
        chk("rip_second_rd1", RD1_READY, !FIXED);
        step();
        smp();
        chk("rip_credit_rd0", RD0_READY, 0);
        chk("rip_credit_rd1", RD1_READY, 0);
        step();
        RSP_READY = 1'b1; RD0_VALID = 1'b0; RD1_VALID = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
